// File: rtl/spi_reg_peripheral.sv
// ---------------------------------------------------------------------------
// spi_reg_peripheral
//
// SPI Mode-0 write-only slave that owns the five 8-bit configuration
// registers of the downstream PWM peripheral. The SPI pins are asynchronous
// to clk, so each one is synchronised and edge-detected before the frame
// FSM uses it. A frame is 16 bits long and sent MSB first:
//   bit 15    : R/W (1 = write)
//   bits 14:8 : register address
//   bits 7:0  : data
// Only well-formed write frames to an existing address update a register.
// Every other frame is dropped without side effects.
//
// Ports:
//   clk             system clock; SCLK phases must each be >= 4 clk periods
//   rst             synchronous reset, active-high
//   sclk            SPI clock, asynchronous
//   copi            SPI data in, asynchronous, MSB first
//   ncs             SPI chip select, active-low, asynchronous
//   en_reg_out_7_0  register at address 0x00
//   en_reg_out_15_8 register at address 0x01
//   en_reg_pwm_7_0  register at address 0x02
//   en_reg_pwm_15_8 register at address 0x03
//   pwm_duty_cycle  register at address 0x04
//   wr_commit       one-clk pulse for each accepted write
// ---------------------------------------------------------------------------
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_commit
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  localparam logic [6:0] MaxAddr = 7'(MAX_ADDR);

  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] copiSync_q;
  logic [SYNC_STAGES-1:0] ncsSync_q;
  logic                   sclkHist_q;
  logic                   ncsHist_q;

  state_e      state_q;
  logic [15:0] shiftReg_q;
  logic [4:0]  bitCnt_q;
  logic        overflow_q;
  logic        wrCommit_q;
  logic [7:0]  reg0_q, reg1_q, reg2_q, reg3_q, reg4_q;

  logic sclkRise;
  logic ncsRise;
  logic ncsFall;
  logic copiBit;
  logic writeOk;

  // Synchroniser chains plus one history flop per edge-detected pin.
  // ncs clears to 1 so that reset looks like an idle (deselected) bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclkSync_q <= '0;
      copiSync_q <= '0;
      ncsSync_q  <= '1;
      sclkHist_q <= 1'b0;
      ncsHist_q  <= 1'b1;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk};
      copiSync_q <= {copiSync_q[SYNC_STAGES-2:0], copi};
      ncsSync_q  <= {ncsSync_q[SYNC_STAGES-2:0], ncs};
      sclkHist_q <= sclkSync_q[SYNC_STAGES-1];
      ncsHist_q  <= ncsSync_q[SYNC_STAGES-1];
    end
  end

  // copi goes through the same depth as sclk, so the bit seen alongside a
  // detected rising edge is the one that was on the pin at that SCLK edge.
  assign sclkRise = sclkSync_q[SYNC_STAGES-1] & ~sclkHist_q;
  assign ncsRise  = ncsSync_q[SYNC_STAGES-1] & ~ncsHist_q;
  assign ncsFall  = ~ncsSync_q[SYNC_STAGES-1] & ncsHist_q;
  assign copiBit  = copiSync_q[SYNC_STAGES-1];

  // A frame is accepted only if it is exactly 16 bits, a write, and
  // addresses an implemented register.
  assign writeOk = (bitCnt_q == 5'd16) && !overflow_q && shiftReg_q[15] &&
                   (shiftReg_q[14:8] <= MaxAddr);

  // Frame FSM. The overflow flag is sticky for the frame so that a 17th
  // (or later) bit cannot be masked by the saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      bitCnt_q   <= '0;
      overflow_q <= 1'b0;
      wrCommit_q <= 1'b0;
      reg0_q     <= '0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      reg3_q     <= '0;
      reg4_q     <= '0;
    end else begin
      wrCommit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ncsFall) begin
            state_q    <= SHIFT;
            bitCnt_q   <= '0;
            overflow_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (ncsRise) begin
            state_q <= COMMIT;
          end else if (sclkRise) begin
            shiftReg_q <= {shiftReg_q[14:0], copiBit};
            if (bitCnt_q == 5'd16) begin
              overflow_q <= 1'b1;
            end else begin
              bitCnt_q <= bitCnt_q + 5'd1;
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          if (writeOk) begin
            wrCommit_q <= 1'b1;
            case (shiftReg_q[14:8])
              7'd0:    reg0_q <= shiftReg_q[7:0];
              7'd1:    reg1_q <= shiftReg_q[7:0];
              7'd2:    reg2_q <= shiftReg_q[7:0];
              7'd3:    reg3_q <= shiftReg_q[7:0];
              7'd4:    reg4_q <= shiftReg_q[7:0];
              default: ;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = reg0_q;
  assign en_reg_out_15_8 = reg1_q;
  assign en_reg_pwm_7_0  = reg2_q;
  assign en_reg_pwm_15_8 = reg3_q;
  assign pwm_duty_cycle  = reg4_q;
  assign wr_commit       = wrCommit_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_peripheral
//
// Self-checking bench for spi_reg_peripheral. Drives SPI frames bit-banged
// from the clk negedge with every SCLK phase 6 clk long, and compares the
// five registers (packed {addr4..addr0}) and the number of wr_commit pulses
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_spi_reg_peripheral;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] regOut0, regOut1, regPwm0, regPwm1, pwmDuty;
  logic       wrCommit;

  int vectorCount = 0;
  int missCount   = 0;
  int commitCount = 0;
  int commitsBefore;

  typedef struct {
    string       name;
    logic [31:0] frame;
    int          nbits;
    logic [39:0] expRegs;
    int          expCommits;
  } vector_t;

  vector_t vectors [9];

  spi_reg_peripheral dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (regOut0),
    .en_reg_out_15_8 (regOut1),
    .en_reg_pwm_7_0  (regPwm0),
    .en_reg_pwm_15_8 (regPwm1),
    .pwm_duty_cycle  (pwmDuty),
    .wr_commit       (wrCommit)
  );

  always #5 clk = ~clk;

  // Counts clk cycles with wr_commit high, so a stretched pulse also shows.
  always @(negedge clk) begin
    if (wrCommit === 1'b1) commitCount++;
  end

  function automatic logic [39:0] regsNow();
    return {pwmDuty, regPwm1, regPwm0, regOut1, regOut0};
  endfunction

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frameStart();
    ncs = 1'b0;
    waitClk(6);
  endtask

  task automatic shiftBits(input logic [31:0] value, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = value[i];
      waitClk(6);
      sclk = 1'b1;
      waitClk(6);
      sclk = 1'b0;
    end
  endtask

  task automatic frameEnd();
    waitClk(6);
    ncs = 1'b1;
  endtask

  task automatic applyStimulus(input logic [31:0] value, input int nbits);
    frameStart();
    shiftBits(value, nbits);
    frameEnd();
  endtask

  task automatic checkOutput(input string name, input logic [39:0] got,
                             input logic [39:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    // Frames after the basic write (addr0 = 0xF0). Rejected frames must
    // leave the accumulated register image untouched. The short and long
    // frames are chosen so that the 16 bits left in the shift register
    // would form a valid write to addr0 if the length checks were missing.
    vectors[0] = '{"wr_addr1",  32'h81AA,  16, 40'h00_00_00_AA_F0, 1};
    vectors[1] = '{"wr_addr2",  32'h8255,  16, 40'h00_00_55_AA_F0, 1};
    vectors[2] = '{"wr_addr3",  32'h83C3,  16, 40'h00_C3_55_AA_F0, 1};
    vectors[3] = '{"wr_addr4",  32'h8480,  16, 40'h80_C3_55_AA_F0, 1};
    vectors[4] = '{"read",      32'h04FF,  16, 40'h80_C3_55_AA_F0, 0};
    vectors[5] = '{"bad_addr",  32'h8511,  16, 40'h80_C3_55_AA_F0, 0};
    vectors[6] = '{"short15",   32'h0022,  15, 40'h80_C3_55_AA_F0, 0};
    vectors[7] = '{"long17",    32'h18033, 17, 40'h80_C3_55_AA_F0, 0};
    vectors[8] = '{"empty",     32'h0,      0, 40'h80_C3_55_AA_F0, 0};

    rst  = 1'b1;
    ncs  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    waitClk(3);
    rst = 1'b0;
    waitClk(2);
    checkOutput("reset_regs",   regsNow(), 40'h0);
    checkOutput("reset_commit", 40'(wrCommit), 40'h0);

    // Basic write with exact latency: ncs rises at a negedge, so the next
    // posedge is the first to sample it; results appear after the 4th.
    frameStart();
    shiftBits(32'h80F0, 16);
    waitClk(6);
    ncs = 1'b1;
    waitClk(3);
    checkOutput("lat_early_reg",    40'(regOut0), 40'h00);
    checkOutput("lat_early_commit", 40'(wrCommit), 40'h0);
    waitClk(1);
    checkOutput("lat_reg",      regsNow(), 40'h00_00_00_00_F0);
    checkOutput("lat_commit",   40'(wrCommit), 40'h1);
    waitClk(1);
    checkOutput("lat_pulse_end", 40'(wrCommit), 40'h0);
    waitClk(6);

    foreach (vectors[i]) begin
      commitsBefore = commitCount;
      applyStimulus(vectors[i].frame, vectors[i].nbits);
      waitClk(10);
      checkOutput({vectors[i].name, "_regs"}, regsNow(), vectors[i].expRegs);
      checkOutput({vectors[i].name, "_commits"},
                  40'(commitCount - commitsBefore), 40'(vectors[i].expCommits));
    end

    // Reset while idle clears everything.
    rst = 1'b1;
    waitClk(2);
    rst = 1'b0;
    waitClk(1);
    checkOutput("idle_reset_regs",   regsNow(), 40'h0);
    checkOutput("idle_reset_commit", 40'(wrCommit), 40'h0);

    // Reset in the middle of a frame with ncs held low: the tail must not
    // produce a write.
    commitsBefore = commitCount;
    frameStart();
    shiftBits(32'h84, 8);
    waitClk(3);
    rst = 1'b1;
    waitClk(2);
    rst = 1'b0;
    waitClk(2);
    shiftBits(32'h33, 8);
    frameEnd();
    waitClk(10);
    checkOutput("midrst_regs",    regsNow(), 40'h0);
    checkOutput("midrst_commits", 40'(commitCount - commitsBefore), 40'h0);
    commitsBefore = commitCount;
    applyStimulus(32'h8433, 16);
    waitClk(10);
    checkOutput("after_midrst_regs",    regsNow(), 40'h33_00_00_00_00);
    checkOutput("after_midrst_commits", 40'(commitCount - commitsBefore), 40'h1);

    // SCLK noise while deselected, then two frames with 4 clk of ncs high.
    for (int i = 0; i < 5; i++) begin
      copi = 1'($urandom_range(1));
      sclk = 1'b1;
      waitClk(5);
      sclk = 1'b0;
      waitClk(5);
    end
    checkOutput("noise_regs", regsNow(), 40'h33_00_00_00_00);
    commitsBefore = commitCount;
    applyStimulus(32'h8001, 16);
    waitClk(4);
    checkOutput("gap_first_reg", 40'(regOut0), 40'h01);
    applyStimulus(32'h8002, 16);
    waitClk(10);
    checkOutput("gap_second_regs", regsNow(), 40'h33_00_00_00_02);
    checkOutput("gap_commits", 40'(commitCount - commitsBefore), 40'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
